// File: rtl/mul_div_sequencer.sv
// ---------------------------------------------------------------------------
// mul_div_sequencer
//   Iterative multiply/divide unit with architectural HI/LO registers for a
//   MIPS-style pipeline. Multiply is radix-2 shift-add and divide is radix-2
//   restoring. Both work on operand magnitudes, and the sign is fixed up in a
//   final FIX cycle.
//
//   Optional build macro: MD_FAST_MULT_EN
//     When defined, MULT/MULTU finish in a single RUN cycle using a
//     combinational full-width product. Divide timing does not change.
//     When undefined, every op is iterative and no WIDTH x WIDTH multiplier
//     is built.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   Start           launch request from the EX stage (ignored while Busy)
//   Op[1:0]         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B            multiplicand/dividend and multiplier/divisor
//   HiWrite/LoWrite MTHI/MTLO strobes; WData is the write data
//   ReadHiLo        EX stage is executing MFHI/MFLO this cycle
//   HI, LO          architectural result registers
//   Busy            an operation is in flight (RUN or FIX)
//   Stall           combinational hold request to the pipeline
//   Done            one-cycle completion pulse
//   DivZero         one-cycle pulse with Done for a divide by zero
// ---------------------------------------------------------------------------
module mul_div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WData,
   input  logic             ReadHiLo,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             Stall,
   output logic             Done,
   output logic             DivZero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             res_neg_q, res_neg_d;   // product/quotient must be negated
   logic             rem_neg_q, rem_neg_d;   // remainder takes dividend sign
   logic             dz_q, dz_d;             // divide-by-zero pending for FIX
   logic [WIDTH-1:0] m_q, m_d;               // multiplicand or divisor magnitude
   logic [WIDTH-1:0] ph_q, ph_d;             // product high / partial remainder
   logic [WIDTH-1:0] pl_q, pl_d;             // multiplier bits / dividend->quotient
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             divzero_q, divzero_d;

   // Operand magnitudes for the signed ops. The most-negative value maps onto
   // itself, and read as unsigned that is the correct magnitude.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_neg = ~Op[0] & A[WIDTH-1];
   assign b_neg = ~Op[0] & B[WIDTH-1];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

   // Shift-add step: add the multiplicand into the upper half when the
   // current multiplier LSB is set, then shift the whole 2W pair right.
   logic [WIDTH:0] madd;
   assign madd = {1'b0, ph_q} + (pl_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

   // Restoring step: bring the next dividend bit into the partial remainder
   // and subtract the divisor only if it fits. The remainder stays below the
   // divisor, so the shifted value needs just one extra bit.
   logic [WIDTH:0] dr, dsub;
   logic           dge;
   assign dr   = {ph_q, pl_q[WIDTH-1]};
   assign dge  = (dr >= {1'b0, m_q});
   assign dsub = dr - {1'b0, m_q};

   // Sign fix-up applied in FIX.
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;
   assign prod   = {ph_q, pl_q};
   assign prod_s = res_neg_q ? -prod : prod;
   assign quo_s  = res_neg_q ? -pl_q : pl_q;
   assign rem_s  = rem_neg_q ? -ph_q : ph_q;

`ifdef MD_FAST_MULT_EN
   logic [2*WIDTH-1:0] fprod;
   assign fprod = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, pl_q};
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
      m_d       = m_q;
      ph_d      = ph_q;
      pl_d      = pl_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      divzero_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               // Start takes priority: a write arriving in the same cycle is
               // dropped, because the result will overwrite HI/LO anyway.
               state_d   = S_RUN;
               cnt_d     = '0;
               is_div_d  = Op[1];
               res_neg_d = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               dz_d      = Op[1] & (B == '0);
               ph_d      = '0;
               if (Op[1]) begin
                  m_d  = b_mag;
                  pl_d = a_mag;
               end else begin
                  m_d  = a_mag;
                  pl_d = b_mag;
               end
            end else begin
               if (HiWrite) hi_d = WData;
               if (LoWrite) lo_d = WData;
            end
         end

         S_RUN: begin
            if (is_div_q) begin
               ph_d = dge ? dsub[WIDTH-1:0] : dr[WIDTH-1:0];
               pl_d = {pl_q[WIDTH-2:0], dge};
            end else begin
               ph_d = madd[WIDTH:1];
               pl_d = {madd[0], pl_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
`ifdef MD_FAST_MULT_EN
            if (!is_div_q) begin
               {ph_d, pl_d} = fprod;
               state_d      = S_FIX;
            end
`endif
         end

         S_FIX: begin
            if (is_div_q) begin
               // With a zero divisor every restoring step subtracts 0. The
               // remainder ends up holding the dividend magnitude, so the
               // sign fix gives back A. Only the quotient is forced.
               hi_d = rem_s;
               lo_d = dz_q ? '1 : quo_s;
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
            done_d    = 1'b1;
            divzero_d = dz_q;
            state_d   = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         m_q       <= '0;
         ph_q      <= '0;
         pl_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
         m_q       <= m_d;
         ph_q      <= ph_d;
         pl_q      <= pl_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign Busy    = (state_q != S_IDLE);
   assign Stall   = Busy & (Start | ReadHiLo | HiWrite | LoWrite);
   assign Done    = done_q;
   assign DivZero = divzero_q;

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; supported values 8..32, even only.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 Start  input  1  EX-stage request to launch a multiply/divide; sampled every edge.
REQ-005 Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
REQ-006 A, B  input  WIDTH each  operands (multiplicand/dividend A, multiplier/divisor B); sampled with Start.
REQ-007 HiWrite, LoWrite  input  1 each  MTHI/MTLO strobes.
REQ-008 WData  input  WIDTH  data for HiWrite/LoWrite.
REQ-009 ReadHiLo  input  1  EX stage is executing MFHI/MFLO this cycle.
REQ-010 HI, LO  output  WIDTH each  architectural HI/LO registers.
REQ-011 Busy  output  1  operation in flight.
REQ-012 Stall  output  1  combinational pipeline hold request.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 DivZero  output  1  one-cycle pulse, coincident with Done, for DIV/DIVU with B==0.

Function
REQ-015 FSM states: IDLE, RUN, FIX; Busy = (state != IDLE).
REQ-016 IDLE: Start=1 -> latch Op, |A|, |B| (signed ops) or A, B (unsigned ops), result sign bits; clear iteration counter; go RUN.
REQ-017 RUN: one radix-2 step per cycle (shift-add multiply / restoring divide); after WIDTH steps go FIX.
REQ-018 FIX: apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign); write HI/LO; pulse Done; go IDLE.
REQ-019 Latency: Start sampled at edge N -> HI/LO updated and Done high after edge N+WIDTH+1; Busy high exactly WIDTH+1 cycles.
REQ-020 Multiply result: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
REQ-021 Divide result: LO = quotient, HI = remainder, truncation toward zero.
REQ-022 Divide by zero: normal timing; HI = A, LO = all ones; DivZero pulses with Done.
REQ-023 Signed overflow (A = most-negative, B = -1, DIV): LO = A, HI = 0, DivZero = 0.
REQ-024 Stall = Busy & (Start | ReadHiLo | HiWrite | LoWrite).
REQ-025 Start, HiWrite, LoWrite while Busy: ignored; caller holds them asserted until Stall drops.
REQ-026 In IDLE, HiWrite/LoWrite load WData into HI/LO on the next edge; both set -> both written.
REQ-027 In IDLE, Start with HiWrite or LoWrite in the same cycle: Start taken, write dropped.
REQ-028 In FIX, Stall follows REQ-024; pending requests are served in the following IDLE cycle.
REQ-029 HI/LO hold their value except on FIX completion, REQ-026 writes, or reset.
REQ-030 Op and operands are not re-sampled during RUN/FIX; input changes have no effect.

Reset
REQ-031 reset=0 at an edge: state IDLE, HI=0, LO=0, counter=0, Busy=0, Done=0, DivZero=0.
REQ-032 Reset during RUN or FIX aborts the operation; HI/LO cleared, no Done pulse.
REQ-033 Stall = 0 while in reset (follows from Busy=0).

Configuration
REQ-034 Macro MD_FAST_MULT_EN.
REQ-035 Defined: MULT/MULTU spend exactly one RUN cycle using a combinational full-width product; Busy high 2 cycles, result after edge N+2; divide unchanged.
REQ-036 Undefined: all ops iterative per REQ-017/REQ-019; no WIDTH x WIDTH multiplier instantiated.

Verification (WIDTH=32)
REQ-037 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 Busy cycles HI=0xFFFFFFFE, LO=0x00000001, Done pulse once.
REQ-038 MULT A=-3, B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; with MD_FAST_MULT_EN, Busy 2 cycles, same result.
REQ-039 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI=7, LO=0xFFFFFFFF, DivZero=1 with Done.
REQ-040 ReadHiLo held during MULT -> Stall=1 every Busy cycle, 0 the cycle after Done; HI/LO read then equal the result.
REQ-041 Start DIV, reset=0 at RUN cycle 10 -> next cycle Busy=0, HI=LO=0, no Done; Start+HiWrite in IDLE -> operation runs, HI not written from WData.
